// File: rtl/sm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm_pkg
//  Description : Shared state encoding and stream-header field layout for the
//                SM loader and its run timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } sm_state_e;

    // Header: [ADDR_LSB +: AW] start address, [CNT_LSB +: AW] count-1, MSB = LAST.
    localparam int HDR_ADDR_LSB = 0;

    function automatic int HDR_CNT_LSB(input int addr_width);
        return HDR_ADDR_LSB + addr_width;
    endfunction

    function automatic int HDR_LAST_BIT(input int in_width);
        return in_width - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm_run_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sm_run_timer
//  Description : RUN-phase cycle counter; flags expiry on cycle RUN_TIMEOUT-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_run_timer #(
    parameter int RUN_TIMEOUT = 1024,
    parameter int TMR_WIDTH   = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TMR_WIDTH-1:0] c_LIMIT = TMR_WIDTH'(RUN_TIMEOUT - 1);

    logic [TMR_WIDTH-1:0] r_count_q;
    logic [TMR_WIDTH-1:0] w_count_d;

    // Saturates at the limit so a stuck enable can never wrap back to zero.
    always_comb begin
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = '0;
        end else if (i_enable && (r_count_q != c_LIMIT)) begin
            w_count_d = r_count_q + TMR_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_expired = i_enable && (r_count_q == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/sm_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sm_loader
//  Description : Loads framed stream words into CODE/DATA RAM, then runs the
//                SM core until RDY or timeout and latches its result.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_loader
    import sm_pkg::*;
#(
    parameter int ADDR_WIDTH   = 7,
    parameter int IN_WIDTH     = 21,
    parameter int RESULT_WIDTH = 16,
    parameter int RUN_TIMEOUT  = 1024,
    parameter int TMR_WIDTH    = 10
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_VALID,
    input  logic [IN_WIDTH-1:0]     i_DATA,
    output logic                    o_READY,
    output logic                    o_WE,
    output logic [ADDR_WIDTH-1:0]   o_ADDRESS,
    output logic [IN_WIDTH-1:0]     o_DATA,
    output logic                    o_CORE_HOLD,
    input  logic                    i_RDY,
    input  logic                    i_ERROR,
    input  logic [RESULT_WIDTH-1:0] i_RESULT,
    output logic                    o_DONE,
    output logic [RESULT_WIDTH-1:0] o_RESULT,
    output logic                    o_ERROR,
    output logic                    o_TIMEOUT
);

    localparam int c_CNT_LSB  = HDR_CNT_LSB(ADDR_WIDTH);
    localparam int c_LAST_BIT = HDR_LAST_BIT(IN_WIDTH);

    sm_state_e               r_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0]   r_cnt_q, w_cnt_d;
    logic                    r_last_q, w_last_d;
    logic                    r_we_q, w_we_d;
    logic [ADDR_WIDTH-1:0]   r_wr_addr_q, w_wr_addr_d;
    logic [IN_WIDTH-1:0]     r_wr_data_q, w_wr_data_d;
    logic [RESULT_WIDTH-1:0] r_result_q, w_result_d;
    logic                    r_error_q, w_error_d;
    logic                    r_timeout_q, w_timeout_d;

    logic w_accept;
    logic w_run;
    logic w_expired;

    assign o_READY  = (r_state_q == ST_IDLE) || (r_state_q == ST_LOAD) || (r_state_q == ST_DONE);
    assign w_accept = i_VALID && o_READY;
    assign w_run    = (r_state_q == ST_RUN);

    sm_run_timer #(
        .RUN_TIMEOUT (RUN_TIMEOUT),
        .TMR_WIDTH   (TMR_WIDTH)
    ) u_run_timer (
        .i_clk     (i_CLK),
        .i_rst     (i_RST),
        .i_clear   (!w_run),
        .i_enable  (w_run),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_addr_d    = r_addr_q;
        w_cnt_d     = r_cnt_q;
        w_last_d    = r_last_q;
        w_we_d      = 1'b0;
        w_wr_addr_d = r_wr_addr_q;
        w_wr_data_d = r_wr_data_q;
        w_result_d  = r_result_q;
        w_error_d   = r_error_q;
        w_timeout_d = r_timeout_q;

        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_addr_d    = i_DATA[HDR_ADDR_LSB +: ADDR_WIDTH];
                    w_cnt_d     = i_DATA[c_CNT_LSB +: ADDR_WIDTH];
                    w_last_d    = i_DATA[c_LAST_BIT];
                    w_result_d  = '0;
                    w_error_d   = 1'b0;
                    w_timeout_d = 1'b0;
                    w_state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_we_d      = 1'b1;
                    w_wr_addr_d = r_addr_q;
                    w_wr_data_d = i_DATA;
                    w_addr_d    = r_addr_q + ADDR_WIDTH'(1);
                    // r_cnt_q holds words remaining minus one.
                    if (r_cnt_q == '0) begin
                        w_state_d = r_last_q ? ST_ARM : ST_IDLE;
                    end else begin
                        w_cnt_d = r_cnt_q - ADDR_WIDTH'(1);
                    end
                end
            end
            ST_ARM: begin
                w_state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_RDY) begin
                    w_result_d  = i_RESULT;
                    w_error_d   = i_ERROR;
                    w_timeout_d = 1'b0;
                    w_state_d   = ST_DONE;
                end else if (w_expired) begin
                    w_result_d  = '0;
                    w_error_d   = 1'b1;
                    w_timeout_d = 1'b1;
                    w_state_d   = ST_DONE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state_q   <= ST_IDLE;
            r_addr_q    <= '0;
            r_cnt_q     <= '0;
            r_last_q    <= 1'b0;
            r_we_q      <= 1'b0;
            r_wr_addr_q <= '0;
            r_wr_data_q <= '0;
            r_result_q  <= '0;
            r_error_q   <= 1'b0;
            r_timeout_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_addr_q    <= w_addr_d;
            r_cnt_q     <= w_cnt_d;
            r_last_q    <= w_last_d;
            r_we_q      <= w_we_d;
            r_wr_addr_q <= w_wr_addr_d;
            r_wr_data_q <= w_wr_data_d;
            r_result_q  <= w_result_d;
            r_error_q   <= w_error_d;
            r_timeout_q <= w_timeout_d;
        end
    end

    assign o_WE        = r_we_q;
    assign o_ADDRESS   = r_wr_addr_q;
    assign o_DATA      = r_wr_data_q;
    assign o_CORE_HOLD = !w_run;
    assign o_DONE      = (r_state_q == ST_DONE);
    assign o_RESULT    = r_result_q;
    assign o_ERROR     = r_error_q;
    assign o_TIMEOUT   = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_loader
//  Description : Directed plus randomized bench for sm_loader against a
//                header-arithmetic reference of expected writes and run results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_loader;

    localparam int AW = 7;
    localparam int IW = 21;
    localparam int RW = 16;
    localparam int TO = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [IW-1:0] i_data;
    logic          i_rdy;
    logic          i_error;
    logic [RW-1:0] i_result;
    wire           o_ready;
    wire           o_we;
    wire  [AW-1:0] o_address;
    wire  [IW-1:0] o_data;
    wire           o_core_hold;
    wire           o_done;
    wire  [RW-1:0] o_result;
    wire           o_error;
    wire           o_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    logic [IW-1:0] payload_q[$];

    sm_loader #(
        .ADDR_WIDTH   (AW),
        .IN_WIDTH     (IW),
        .RESULT_WIDTH (RW),
        .RUN_TIMEOUT  (TO),
        .TMR_WIDTH    (5)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_VALID     (i_valid),
        .i_DATA      (i_data),
        .o_READY     (o_ready),
        .o_WE        (o_we),
        .o_ADDRESS   (o_address),
        .o_DATA      (o_data),
        .o_CORE_HOLD (o_core_hold),
        .i_RDY       (i_rdy),
        .i_ERROR     (i_error),
        .i_RESULT    (i_result),
        .o_DONE      (o_done),
        .o_RESULT    (o_result),
        .o_ERROR     (o_error),
        .o_TIMEOUT   (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] hdr(input int start, input int cntm1, input bit last);
        logic [IW-1:0] h;
        h        = '0;
        h[6:0]   = start[6:0];
        h[13:7]  = cntm1[6:0];
        h[19:14] = 6'($urandom);
        h[20]    = last;
        return h;
    endfunction

    task automatic check_reset();
        check("rst_ready",   o_ready,     1);
        check("rst_we",      o_we,        0);
        check("rst_addr",    o_address,   0);
        check("rst_data",    o_data,      0);
        check("rst_hold",    o_core_hold, 1);
        check("rst_done",    o_done,      0);
        check("rst_result",  o_result,    0);
        check("rst_error",   o_error,     0);
        check("rst_timeout", o_timeout,   0);
    endtask

    // Offers one word after a random stall; a payload must be written one cycle after acceptance.
    task automatic send(input logic [IW-1:0] w, input bit payload, input int eaddr, input int max_stall);
        int stalls;
        stalls = $urandom_range(0, max_stall);
        for (int s = 0; s < stalls; s++) begin
            i_valid = 1'b0;
            i_data  = IW'($urandom);
            step();
            check("stall_we", o_we, 0);
        end
        i_valid = 1'b1;
        i_data  = w;
        check("accept_ready", o_ready, 1);
        step();
        i_valid = 1'b0;
        if (payload) begin
            check("wr_we",   o_we,      1);
            check("wr_addr", o_address, eaddr);
            check("wr_data", o_data,    w);
        end else begin
            check("hdr_we", o_we, 0);
        end
    endtask

    task automatic load_segment(input int start, input int cntm1, input bit last,
                                input int max_stall, input int n_send);
        send(hdr(start, cntm1, last), 1'b0, 0, max_stall);
        check("hdr_done_clr",    o_done,      0);
        check("hdr_hold",        o_core_hold, 1);
        check("hdr_result_clr",  o_result,    0);
        check("hdr_error_clr",   o_error,     0);
        check("hdr_timeout_clr", o_timeout,   0);
        for (int i = 0; i < n_send; i++) begin
            logic [IW-1:0] w;
            if (payload_q.size() > 0) w = payload_q.pop_front();
            else                      w = IW'($urandom);
            send(w, 1'b1, (start + i) % 128, max_stall);
        end
        if (n_send == cntm1 + 1) begin
            if (last) begin
                check("arm_ready", o_ready,     0);
                check("arm_hold",  o_core_hold, 1);
            end else begin
                check("seg_idle_ready", o_ready,     1);
                check("seg_idle_hold",  o_core_hold, 1);
            end
        end
    endtask

    // Entered in the ARM cycle. RUN cycle k sees timer value k; RDY wins over expiry.
    task automatic run_phase(input int rdy_at, input logic [RW-1:0] res, input bit er, input bit arm_rdy);
        int k_end;
        bit normal;
        normal   = (rdy_at <= TO - 1);
        k_end    = normal ? rdy_at : TO - 1;
        i_rdy    = arm_rdy;
        i_result = RW'($urandom);
        i_error  = 1'($urandom);
        step();
        i_rdy = 1'b0;
        check("run_hold",  o_core_hold, 0);
        check("run_ready", o_ready,     0);
        check("run_done",  o_done,      0);
        check("run_we",    o_we,        0);
        for (int k = 0; k <= k_end; k++) begin
            i_rdy    = (k == rdy_at);
            i_result = (k == rdy_at) ? res : RW'($urandom);
            i_error  = (k == rdy_at) ? er  : 1'($urandom);
            step();
            if (k < k_end) begin
                check("run_wait_done", o_done,      0);
                check("run_wait_hold", o_core_hold, 0);
            end
        end
        i_rdy = 1'b0;
        check("done_flag",    o_done,      1);
        check("done_hold",    o_core_hold, 1);
        check("done_ready",   o_ready,     1);
        check("done_result",  o_result,    normal ? res : '0);
        check("done_error",   o_error,     normal ? er : 1'b1);
        check("done_timeout", o_timeout,   normal ? 1'b0 : 1'b1);
        for (int h = 0; h < 3; h++) begin
            i_rdy    = 1'($urandom);
            i_result = RW'($urandom);
            i_error  = 1'($urandom);
            step();
            check("held_done",    o_done,    1);
            check("held_result",  o_result,  normal ? res : '0);
            check("held_timeout", o_timeout, normal ? 1'b0 : 1'b1);
        end
        i_rdy = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_rdy    = 1'b0;
        i_error  = 1'b0;
        i_result = '0;
        step();
        step();
        rst = 1'b0;
        check_reset();

        // Non-final segment of three fixed words at 0..2.
        payload_q.push_back(21'h1A2B3);
        payload_q.push_back(21'h00001);
        payload_q.push_back(21'h1FFFF);
        load_segment(0, 2, 1'b0, 0, 3);
        step();
        check("idle_we_clear", o_we,        0);
        check("idle_hold",     o_core_hold, 1);

        // Final segment wrapping 0x7E,0x7F,0x00, then core completes after 20 cycles.
        load_segment(8'h7E, 2, 1'b1, 0, 3);
        run_phase(20, 16'h00AB, 1'b0, 1'b0);

        // From DONE: new load crossing the code/data boundary, then timeout.
        load_segment(8'h3F, 1, 1'b1, 0, 2);
        run_phase(TO + 5, 16'h5555, 1'b0, 1'b0);

        // RDY on the expiry cycle wins; RDY during ARM is ignored.
        load_segment($urandom_range(0, 127), 0, 1'b1, 1, 1);
        run_phase(TO - 1, 16'h1234, 1'b1, 1'b1);

        // Reset mid-segment, then a clean restart.
        load_segment(8'h10, 9, 1'b1, 2, 3);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = IW'($urandom);
        step();
        rst     = 1'b0;
        i_valid = 1'b0;
        check_reset();
        load_segment(8'h10, 3, 1'b0, 1, 4);

        // Reset mid-run re-holds the core on the same edge.
        load_segment(8'h20, 1, 1'b1, 0, 2);
        step();
        check("midrun_hold", o_core_hold, 0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset();

        // Maximum segment length: 128 words covering the whole address space.
        load_segment($urandom_range(0, 127), 127, 1'b0, 0, 128);

        // Randomized segments with stalls and random run outcomes.
        for (int it = 0; it < 8; it++) begin
            int  start;
            int  cntm1;
            bit  last;
            start = $urandom_range(0, 127);
            cntm1 = $urandom_range(0, 5);
            last  = 1'($urandom);
            load_segment(start, cntm1, last, 3, cntm1 + 1);
            if (last) begin
                run_phase($urandom_range(0, TO + 2), RW'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
